// File: rtl/serial_negate_ctrl.sv
// Word-level sequencer around a one-bit two's-complement converter: accepts a parallel word,
// streams it LSB-first through the converter and reassembles the serial result.
module serial_negate_ctrl #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CONV_LAT = 0
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy,
   output logic             ser_i,
   output logic             ser_r,
   input  logic             ser_y
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StClr   = 3'd1;
   localparam logic [2:0] StShift = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] data_q;
   logic             ovf_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [1:0]       drain_cnt_q;
   logic             accept;
   logic             shifting;
   logic             last_bit;
   logic             last_drain;
   logic             cap_en;

   assign accept     = (state_q == StIdle) && in_valid;
   assign shifting   = (state_q == StShift);
   assign last_bit   = (bit_cnt_q == CNT_W'(WIDTH - 1));
   assign last_drain = (drain_cnt_q == 2'(CONV_LAT - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = in_neg ? StClr : StDone;
         StClr:   state_d = StShift;
         StShift: if (last_bit) state_d = (CONV_LAT > 0) ? StDrain : StDone;
         StDrain: if (last_drain) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // The capture window trails the SHIFT window by the converter latency.
   if (CONV_LAT == 0) begin : g_no_lat
      assign cap_en = shifting;
   end else begin : g_lat
      logic [CONV_LAT-1:0] cap_q;
      always_ff @(posedge t_clk) begin
         if (r) cap_q <= '0;
         else   cap_q <= (cap_q << 1) | CONV_LAT'(shifting);
      end
      assign cap_en = cap_q[CONV_LAT-1];
   end

   always_ff @(posedge t_clk) begin
      if (r) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         data_q      <= '0;
         ovf_q       <= 1'b0;
         bit_cnt_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            shift_q <= in_data;
            ovf_q   <= in_neg && (in_data == MostNeg);
            if (!in_neg) data_q <= in_data;
         end else begin
            if (shifting) shift_q <= shift_q >> 1;
            // Serial result enters at the MSB so bit k lands in place after WIDTH captures.
            if (cap_en) data_q <= {ser_y, data_q[WIDTH-1:1]};
         end
         if (state_q == StClr)  bit_cnt_q <= '0;
         else if (shifting)     bit_cnt_q <= bit_cnt_q + 1'b1;
         if (shifting)               drain_cnt_q <= '0;
         else if (state_q == StDrain) drain_cnt_q <= drain_cnt_q + 1'b1;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_data  = data_q;
   assign out_ovf   = ovf_q;
   assign ser_i     = shifting && !r && shift_q[0];
   assign ser_r     = r || (state_q == StClr);

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl with behavioural converters at latency 0 and 2.
module tb_serial_negate_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic r = 1'b1;
   int total = 0;
   int bad = 0;

   logic       iv0 = 0, in0 = 0, or0 = 0;
   logic [7:0] id0 = 8'h00;
   logic       ir0, ov0, ovf0, busy0, si0, sr0, sy0;
   logic [7:0] od0;

   logic       iv2 = 0, in2 = 0, or2 = 0;
   logic [7:0] id2 = 8'h00;
   logic       ir2, ov2, ovf2, busy2, si2, sr2, sy2;
   logic [7:0] od2;

   serial_negate_ctrl #(.WIDTH(8), .CONV_LAT(0)) dut0 (
      .t_clk(clk), .r(r), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_neg(in0),
      .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ovf(ovf0), .busy(busy0),
      .ser_i(si0), .ser_r(sr0), .ser_y(sy0)
   );

   serial_negate_ctrl #(.WIDTH(8), .CONV_LAT(2)) dut2 (
      .t_clk(clk), .r(r), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_neg(in2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ovf(ovf2), .busy(busy2),
      .ser_i(si2), .ser_r(sr2), .ser_y(sy2)
   );

   // Converter models: y = x XOR seen_one, seen_one cleared by ser_r.
   logic seen0 = 1'b0, seen2 = 1'b0, d2a = 1'b0, d2b = 1'b0;
   assign sy0 = si0 ^ seen0;
   assign sy2 = d2b;
   always @(posedge clk) begin
      if (sr0)      seen0 <= 1'b0;
      else if (si0) seen0 <= 1'b1;
      if (sr2)      seen2 <= 1'b0;
      else if (si2) seen2 <= 1'b1;
      d2a <= si2 ^ seen2;
      d2b <= d2a;
   end

   // Offers one word, returns edges from accept to out_valid and ser_r high samples seen.
   task automatic send(input bit sel, input bit neg, input logic [7:0] d,
                       output int edges, output int srp);
      if (sel) begin iv2 = 1; in2 = neg; id2 = d; end
      else     begin iv0 = 1; in0 = neg; id0 = d; end
      @(posedge clk); #1;
      iv0 = 0; iv2 = 0; in0 = 0; in2 = 0;
      edges = 0;
      srp = 0;
      while (!(sel ? ov2 : ov0) && edges < 40) begin
         srp += int'(sel ? sr2 : sr0);
         @(posedge clk); #1;
         edges++;
      end
      srp += int'(sel ? sr2 : sr0);
   endtask

   task automatic release_out(input bit sel);
      if (sel) or2 = 1; else or0 = 1;
      @(posedge clk); #1;
      or0 = 0; or2 = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ir0); end
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov0); end
      total++; if (od0 !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", od0); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf0); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy0); end
      total++; if (si0 !== 1'b0) begin bad++; $display("FAIL reset_ser_i got=%b want=0", si0); end
      total++; if (sr0 !== 1'b1) begin bad++; $display("FAIL reset_ser_r got=%b want=1", sr0); end
      total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready2 got=%b want=1", ir2); end
      r = 0;
      @(posedge clk); #1;
      total++; if (sr0 !== 1'b0) begin bad++; $display("FAIL idle_ser_r got=%b want=0", sr0); end
   endtask

   task automatic test_negate();
      int e, s;
      logic [7:0] ops [3] = '{8'h01, 8'h06, 8'h00};
      logic [7:0] exp [3] = '{8'hFF, 8'hFA, 8'h00};
      for (int i = 0; i < 3; i++) begin
         send(0, 1, ops[i], e, s);
         total++; if (e != 9) begin bad++; $display("FAIL neg_latency op=%h got=%0d want=9", ops[i], e); end
         total++; if (od0 !== exp[i]) begin bad++; $display("FAIL neg_data op=%h got=%h want=%h", ops[i], od0, exp[i]); end
         total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL neg_ovf op=%h got=%b want=0", ops[i], ovf0); end
         total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL done_in_ready got=%b want=0", ir0); end
         release_out(0);
         total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b want=1", ir0); end
      end
   endtask

   task automatic test_ovf();
      int e, s;
      send(0, 1, 8'h80, e, s);
      total++; if (od0 !== 8'h80) begin bad++; $display("FAIL ovf_data got=%h want=80", od0); end
      total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ovf0); end
      release_out(0);
      send(0, 1, 8'h7F, e, s);
      total++; if (od0 !== 8'h81) begin bad++; $display("FAIL max_pos_data got=%h want=81", od0); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL max_pos_ovf got=%b want=0", ovf0); end
      release_out(0);
   endtask

   task automatic test_pass();
      int e, s;
      send(0, 0, 8'h5A, e, s);
      total++; if (e != 0) begin bad++; $display("FAIL pass_latency got=%0d want=0", e); end
      total++; if (od0 !== 8'h5A) begin bad++; $display("FAIL pass_data got=%h want=5a", od0); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL pass_ovf got=%b want=0", ovf0); end
      total++; if (s != 0) begin bad++; $display("FAIL pass_ser_r got=%0d want=0", s); end
      release_out(0);
      total++; if (sr0 !== 1'b0) begin bad++; $display("FAIL pass_ser_r_after got=%b want=0", sr0); end
   endtask

   task automatic test_backpressure();
      int e, s;
      send(0, 1, 8'h06, e, s);
      iv0 = 1; in0 = 0; id0 = 8'h33;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++; if (ov0 !== 1'b1 || od0 !== 8'hFA || ir0 !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d valid=%b data=%h ready=%b want 1/fa/0", i, ov0, od0, ir0);
         end
      end
      or0 = 1;
      @(posedge clk); #1;
      or0 = 0;
      total++; if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
         bad++; $display("FAIL bp_release ready=%b valid=%b want 1/0", ir0, ov0);
      end
      @(posedge clk); #1;
      iv0 = 0;
      total++; if (ov0 !== 1'b1 || od0 !== 8'h33) begin
         bad++; $display("FAIL bp_next_word valid=%b data=%h want 1/33", ov0, od0);
      end
      release_out(0);
   endtask

   task automatic test_reset_mid();
      int e, s;
      iv0 = 1; in0 = 1; id0 = 8'h06;
      @(posedge clk); #1;
      iv0 = 0; in0 = 0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy0); end
      r = 1;
      #1;
      total++; if (sr0 !== 1'b1 || si0 !== 1'b0) begin
         bad++; $display("FAIL mid_reset_ser ser_r=%b ser_i=%b want 1/0", sr0, si0);
      end
      @(posedge clk); #1;
      total++; if (ir0 !== 1'b1 || ov0 !== 1'b0 || busy0 !== 1'b0 || sr0 !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_state ready=%b valid=%b busy=%b ser_r=%b want 1/0/0/1", ir0, ov0, busy0, sr0);
      end
      r = 0;
      @(posedge clk); #1;
      send(0, 1, 8'h01, e, s);
      total++; if (od0 !== 8'hFF || e != 9) begin
         bad++; $display("FAIL after_reset_neg data=%h edges=%0d want ff/9", od0, e);
      end
      release_out(0);
   endtask

   task automatic test_lat2();
      int e, s;
      send(1, 1, 8'h06, e, s);
      total++; if (e != 11) begin bad++; $display("FAIL lat2_latency got=%0d want=11", e); end
      total++; if (od2 !== 8'hFA) begin bad++; $display("FAIL lat2_data got=%h want=fa", od2); end
      release_out(1);
      send(1, 1, 8'h80, e, s);
      total++; if (od2 !== 8'h80 || ovf2 !== 1'b1) begin
         bad++; $display("FAIL lat2_ovf data=%h ovf=%b want 80/1", od2, ovf2);
      end
      release_out(1);
      total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL lat2_ready got=%b want=1", ir2); end
   endtask

   initial begin
      test_reset();
      test_negate();
      test_ovf();
      test_pass();
      test_backpressure();
      test_reset_mid();
      test_lat2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
